// File: rtl/gpio_input_conditioner.sv
// GPIO input front end: pad synchroniser, per-bit debounce, edge capture and level interrupt.
// Optional debounce counters are built only when GPIO_IN_DEBOUNCE_EN is defined.
module gpio_input_conditioner #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wea,
    input  logic [15:0]       addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    input  logic [WIDTH-1:0]  pin_i,
    output logic [WIDTH-1:0]  gpio_i_o,
    output logic              irq_o
);
    localparam logic [15:0] ADDR_PENDING = 16'hfff0;
    localparam logic [15:0] ADDR_RISE_EN = 16'hfff4;
    localparam logic [15:0] ADDR_FALL_EN = 16'hfff8;
    localparam logic [15:0] ADDR_STATUS  = 16'hfffc;

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] stable_reg;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] pending_reg;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] rise_en_reg;
    logic [WIDTH-1:0] fall_en_reg;
    logic [WIDTH-1:0] w1c_mask;
    logic             irq_reg;
    logic             unused_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= '0;
            end
        end else begin
            sync_reg[0] <= pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // accept fires on the cycle the differing level has persisted long enough
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        logic [CW-1:0] cnt_reg;
        logic          differ;

        assign differ     = synced[gi] ^ stable_reg[gi];
        assign accept[gi] = differ && (cnt_reg == CNT_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (!differ || accept[gi]) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end
`else
    assign accept = synced ^ stable_reg;
`endif

    // Set from a new edge wins over a same-cycle write-1-to-clear; enables are the pre-write values
    assign w1c_mask     = (wea && addr == ADDR_PENDING) ? din[WIDTH-1:0] : '0;
    assign pending_next = (pending_reg & ~w1c_mask)
                        | (accept &  synced & rise_en_reg)
                        | (accept & ~synced & fall_en_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_reg  <= '0;
            pending_reg <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            stable_reg  <= stable_reg ^ accept;
            pending_reg <= pending_next;
            irq_reg     <= |pending_reg;
            if (wea && addr == ADDR_RISE_EN) begin
                rise_en_reg <= din[WIDTH-1:0];
            end
            if (wea && addr == ADDR_FALL_EN) begin
                fall_en_reg <= din[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_PENDING: dout = 32'(pending_reg);
            ADDR_RISE_EN: dout = 32'(rise_en_reg);
            ADDR_FALL_EN: dout = 32'(fall_en_reg);
            ADDR_STATUS:  dout = {16'(synced), 16'(stable_reg)};
            default:      dout = '0;
        endcase
    end

    assign gpio_i_o   = stable_reg;
    assign irq_o      = irq_reg;
    assign unused_din = ^din[31:WIDTH];

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
Input front end for the GPIO block; sits directly upstream of the GPIO register block.
- Synchronises raw pad inputs into clk and debounces each bit.
- Drives the debounced vector onto the GPIO block's input bus, so the upper readback half of that block shows the conditioned value.
- Adds per-bit rising/falling edge capture with a maskable, level interrupt on the same 16-bit-address, word-write slave bus as the GPIO block.

Parameters:
WIDTH, 16, number of input pins (1..16).
SYNC_STAGES, 2, synchroniser flops per bit (>=2).
DEBOUNCE_CYCLES, 4, consecutive cycles a new level must persist before acceptance (>=1, <=65535).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  reset, asynchronous, active-high (applied on posedge rst).
wea  input  1  write strobe, single-cycle, qualified by addr.
addr  input  16  register address.
din  input  32  write data.
dout  output  32  read data, combinational mux of addr.
pin_i  input  WIDTH  raw asynchronous pad inputs.
gpio_i_o  output  WIDTH  debounced levels; connects to GPIO block input bus, zero-extended to 16.
irq_o  output  1  registered interrupt, active-high level.

Behaviour:
- Reset: all synchroniser flops, the stable vector, debounce counters, PENDING, RISE_EN and FALL_EN clear to 0. gpio_i_o=0, irq_o=0.
- Synchroniser: per-bit shift chain of SYNC_STAGES flops. The last stage is "synced".
- Debounce (per bit, independent):
  - The counter clears whenever synced==stable.
  - While they differ, the counter increments each cycle.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the bits still differ, stable<=synced and the counter clears.
  - Any return to equality before then discards the change; the glitch is suppressed.
  - The counter never wraps; its width is clog2(DEBOUNCE_CYCLES+1).
- gpio_i_o = stable.
- Latency: a clean pad change is first sampled at edge 1. stable/gpio_i_o change at edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 6).
- Edge detect: on the edge where stable updates:
  - A 0->1 update sets PENDING[i] if RISE_EN[i].
  - A 1->0 update sets PENDING[i] if FALL_EN[i].
  - Disabled edges are not recorded. Enabling later does not retro-set.
- irq_o <= |PENDING, registered one cycle after PENDING (default: edge 7 after the pad change).
- Register map; reads of the upper bits return 0:
  - 16'hfff0 PENDING: read; write-1-to-clear on din[WIDTH-1:0].
  - 16'hfff4 RISE_EN: read/write din[WIDTH-1:0].
  - 16'hfff8 FALL_EN: read/write din[WIDTH-1:0].
  - 16'hfffc STATUS: read-only; {synced zero-extended to 16, stable zero-extended to 16}. Writes ignored.
  - Any other addr: dout=0, writes ignored. Address 16'hffff belongs to the GPIO block and is not decoded here.
- Simultaneous W1C and new edge on the same bit: set wins, and PENDING stays 1.
- Simultaneous write of RISE_EN/FALL_EN and an edge: the edge uses the old enable value.
- Reset mid-debounce: the counter and stable vector clear. A pad held high across reset is seen as a fresh 0->1 after full latency, and raises PENDING only if RISE_EN has been set by then.

Optional Feature:
GPIO_IN_DEBOUNCE_EN:
- Defined: debounce counters as above.
- Undefined: counters are removed, and stable<=synced every cycle, equivalent to DEBOUNCE_CYCLES=1. Latency becomes SYNC_STAGES+1 edges, and glitches of one synced cycle or longer propagate. The DEBOUNCE_CYCLES parameter is ignored.

Test Plan:
- Defaults, GPIO_IN_DEBOUNCE_EN defined, RISE_EN=16'h0001; pin_i[0] 0->1 held -> gpio_i_o[0]=1 at edge 6, PENDING=16'h0001 at edge 6, irq_o=1 at edge 7.
- pin_i[3] high for 3 cycles then low -> gpio_i_o stays 16'h0000, PENDING stays 0, irq_o stays 0.
- FALL_EN=16'h0010, pin_i[4] held high then low -> PENDING=16'h0010 only on the falling acceptance. Write 16'h0010 to 16'hfff0 -> PENDING=0, irq_o=0 one cycle later.
- W1C of bit 0 issued on the same edge as a bit 0 rising acceptance -> PENDING[0]=1, irq_o remains 1.
- pin_i=16'hffff, assert rst for 2 cycles mid-debounce, set RISE_EN=16'hffff after release -> gpio_i_o=0 during reset, 16'hffff at edge 6 after release, PENDING=16'hffff. Read 16'hfffc -> 32'hffffffff.
- Macro undefined: pin_i[0] pulse of 2 cycles -> gpio_i_o[0] high for 2 cycles, rising at edge 3.
